// File: rtl/cpu_types_pkg.sv
// Types shared by the pipeline-boundary registers of the CPU.
package cpu_types_pkg;

  localparam int PIPE_OCC_W = 2;

  // Encoded so that the value equals the number of held words.
  typedef enum logic [PIPE_OCC_W-1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_t st);
    case (st)
      EMPTY:   occ_of = 2'd0;
      BUSY:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a pipeline boundary: main register feeds
// out_data, the skid register catches one word while downstream stalls.
module pipe_skid_reg
  import cpu_types_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [PIPE_OCC_W-1:0] occupancy,
  output pipe_state_t           dbg_state
);

  // Handshake: a word moves on a side only in a cycle where both valid and
  // ready are high on that side. in_ready is decoded from the state register
  // alone, so out_ready never reaches in_ready combinationally.

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, emit;
  logic             load_main, main_from_skid, load_skid;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);
  assign dbg_state = state_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_d        = BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule
